// File: rtl/mure_uop_fifo_mp_if.sv
// Bundle between the retire-side itype detectors / trace encoder and the multi-port uop FIFO.
// The FIFO itself attaches through the slave modport.
interface mure_uop_fifo_mp_if #(
    parameter int NRET       = 2,
    parameter int DEPTH      = 16,
    parameter int XLEN       = 32,
    parameter int ITYPE_LEN  = 3,
    parameter int PRIV_LEN   = 2,
    parameter int DROP_CNT_W = 16
);
    logic                          flush_i;
    logic [NRET-1:0]               valid_i;
    logic [NRET*XLEN-1:0]          pc_i;
    logic [NRET*ITYPE_LEN-1:0]     itype_i;
    logic [NRET-1:0]               compressed_i;
    logic [NRET*PRIV_LEN-1:0]      priv_i;
    logic                          pop_valid_o;
    logic                          pop_ready_i;
    logic [XLEN-1:0]               pop_pc_o;
    logic [ITYPE_LEN-1:0]          pop_itype_o;
    logic                          pop_compressed_o;
    logic [PRIV_LEN-1:0]           pop_priv_o;
    logic [$clog2(DEPTH):0]        count_o;
    logic                          push_ready_o;
    logic                          overflow_o;
    logic [DROP_CNT_W-1:0]         drop_cnt_o;

    modport master (
        output flush_i, valid_i, pc_i, itype_i, compressed_i, priv_i, pop_ready_i,
        input  pop_valid_o, pop_pc_o, pop_itype_o, pop_compressed_o, pop_priv_o,
        input  count_o, push_ready_o, overflow_o, drop_cnt_o
    );

    modport slave (
        input  flush_i, valid_i, pc_i, itype_i, compressed_i, priv_i, pop_ready_i,
        output pop_valid_o, pop_pc_o, pop_itype_o, pop_compressed_o, pop_priv_o,
        output count_o, push_ready_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/mure_uop_fifo_mp.sv
// Multi-port retired-uop FIFO: compacts up to NRET valid lanes per cycle in lane order,
// drains one uop per cycle, and drops whole pushes that do not fit (sticky flag + counter).
module mure_uop_fifo_mp #(
    parameter int NRET       = 2,
    parameter int DEPTH      = 16,
    parameter int XLEN       = 32,
    parameter int ITYPE_LEN  = 3,
    parameter int PRIV_LEN   = 2,
    parameter int DROP_CNT_W = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    mure_uop_fifo_mp_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = XLEN + ITYPE_LEN + 1 + PRIV_LEN;
    localparam logic [PW-1:0]         PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]         NRET_C   = CW'(NRET);
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2 * NRET) || (NRET < 1) || (NRET > 4)) begin : g_bad_params
        $error("mure_uop_fifo_mp: DEPTH must be a power of two >= 2*NRET, NRET in 1..4");
    end

    logic [EW-1:0]         mem_r [DEPTH];
    logic [PW-1:0]         rd_ptr_r, wr_ptr_r, rd_ptr_next_s, wr_ptr_next_s;
    logic [CW-1:0]         count_r, count_next_s;
    logic                  pop_valid_r, push_ready_r, overflow_r;
    logic                  overflow_next_s;
    logic [DROP_CNT_W-1:0] drop_cnt_r, drop_cnt_next_s;
    logic [DROP_CNT_W:0]   drop_sum_s;
    logic [CW-1:0]         n_s, free_s, n_acc_s;
    logic [CW-1:0]         lane_off_s [NRET];
    logic [PW-1:0]         wr_addr_s  [NRET];
    logic [EW-1:0]         lane_data_s[NRET];
    logic [NRET-1:0]       wr_en_s;
    logic                  push_ok_s, push_drop_s, pop_fire_s;
    logic [EW-1:0]         head_s;

    // Lane compaction: each valid lane lands at wr_ptr + (number of valid lanes below it)
    always_comb begin
        n_acc_s = {CW{1'b0}};
        for (int k = 0; k < NRET; k++) begin
            lane_off_s[k]  = n_acc_s;
            wr_addr_s[k]   = PW'({1'b0, wr_ptr_r} + n_acc_s);
            lane_data_s[k] = {bus.pc_i[k*XLEN +: XLEN],
                              bus.itype_i[k*ITYPE_LEN +: ITYPE_LEN],
                              bus.compressed_i[k],
                              bus.priv_i[k*PRIV_LEN +: PRIV_LEN]};
            if (bus.valid_i[k]) begin
                n_acc_s = n_acc_s + CNT_ONE;
            end else begin
                n_acc_s = n_acc_s;
            end
        end
        n_s = n_acc_s;
    end

    // Free space is judged on the start-of-cycle count; a same-cycle pop never makes room
    always_comb begin
        free_s      = DEPTH_C - count_r;
        push_ok_s   = (n_s != {CW{1'b0}}) && (n_s <= free_s);
        push_drop_s = (n_s > free_s);
        pop_fire_s  = pop_valid_r & bus.pop_ready_i;
        for (int k = 0; k < NRET; k++) begin
            wr_en_s[k] = push_ok_s & bus.valid_i[k] & ~bus.flush_i;
        end
    end

    // Next-state for pointers, occupancy and drop bookkeeping
    always_comb begin
        count_next_s    = count_r;
        wr_ptr_next_s   = wr_ptr_r;
        rd_ptr_next_s   = rd_ptr_r;
        overflow_next_s = overflow_r;
        drop_cnt_next_s = drop_cnt_r;
        drop_sum_s      = {1'b0, drop_cnt_r} + (DROP_CNT_W + 1)'(n_s);
        if (push_ok_s) begin
            wr_ptr_next_s = PW'({1'b0, wr_ptr_r} + n_s);
            count_next_s  = count_r + n_s;
        end else if (push_drop_s) begin
            overflow_next_s = 1'b1;
            if (drop_sum_s[DROP_CNT_W]) begin
                drop_cnt_next_s = DROP_MAX;
            end else begin
                drop_cnt_next_s = drop_sum_s[DROP_CNT_W-1:0];
            end
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_fire_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            count_next_s  = count_next_s - CNT_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Control registers; flush outranks the same-cycle push and pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            pop_valid_r  <= 1'b0;
            push_ready_r <= 1'b1;
            overflow_r   <= 1'b0;
            drop_cnt_r   <= {DROP_CNT_W{1'b0}};
        end else if (bus.flush_i) begin
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            pop_valid_r  <= 1'b0;
            push_ready_r <= 1'b1;
            overflow_r   <= 1'b0;
            drop_cnt_r   <= {DROP_CNT_W{1'b0}};
        end else begin
            rd_ptr_r     <= rd_ptr_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            count_r      <= count_next_s;
            pop_valid_r  <= (count_next_s != {CW{1'b0}});
            push_ready_r <= ((DEPTH_C - count_next_s) >= NRET_C);
            overflow_r   <= overflow_next_s;
            drop_cnt_r   <= drop_cnt_next_s;
        end
    end

    // Entry storage is deliberately left unreset
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NRET; k++) begin
            if (wr_en_s[k]) begin
                mem_r[wr_addr_s[k]] <= lane_data_s[k];
            end
        end
    end

    // Head entry read straight from storage; forced to zero while empty
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (pop_valid_r) begin
            bus.pop_pc_o         = head_s[EW-1 -: XLEN];
            bus.pop_itype_o      = head_s[PRIV_LEN+1 +: ITYPE_LEN];
            bus.pop_compressed_o = head_s[PRIV_LEN];
            bus.pop_priv_o       = head_s[PRIV_LEN-1:0];
        end else begin
            bus.pop_pc_o         = {XLEN{1'b0}};
            bus.pop_itype_o      = {ITYPE_LEN{1'b0}};
            bus.pop_compressed_o = 1'b0;
            bus.pop_priv_o       = {PRIV_LEN{1'b0}};
        end
    end

    assign bus.pop_valid_o  = pop_valid_r;
    assign bus.count_o      = count_r;
    assign bus.push_ready_o = push_ready_r;
    assign bus.overflow_o   = overflow_r;
    assign bus.drop_cnt_o   = drop_cnt_r;
endmodule

// File: tb/tb_mure_uop_fifo_mp.sv
// Self-checking bench for mure_uop_fifo_mp: directed plan steps plus random traffic
// compared against a queue-based reference model.
module tb_mure_uop_fifo_mp;
    localparam int NRET       = 2;
    localparam int DEPTH      = 16;
    localparam int XLEN       = 32;
    localparam int ITYPE_LEN  = 3;
    localparam int PRIV_LEN   = 2;
    localparam int DROP_CNT_W = 16;

    typedef struct {
        logic [XLEN-1:0]      pc;
        logic [ITYPE_LEN-1:0] itype;
        logic                 comp;
        logic [PRIV_LEN-1:0]  priv;
    } uop_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    uop_t q[$];
    int   m_ovf;
    int   m_drop;
    logic [XLEN-1:0] dut_popped[$];

    mure_uop_fifo_mp_if #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .ITYPE_LEN(ITYPE_LEN),
                          .PRIV_LEN(PRIV_LEN), .DROP_CNT_W(DROP_CNT_W)) bus ();

    mure_uop_fifo_mp #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .ITYPE_LEN(ITYPE_LEN),
                       .PRIV_LEN(PRIV_LEN), .DROP_CNT_W(DROP_CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        uop_t h;
        int   sz;
        sz = q.size();
        chk({tag, ".count"},      64'(bus.count_o),      64'(sz));
        chk({tag, ".pop_valid"},  64'(bus.pop_valid_o),  64'(sz != 0));
        chk({tag, ".push_ready"}, 64'(bus.push_ready_o), 64'((DEPTH - sz) >= NRET));
        chk({tag, ".overflow"},   64'(bus.overflow_o),   64'(m_ovf));
        chk({tag, ".drop_cnt"},   64'(bus.drop_cnt_o),   64'(m_drop));
        if (sz != 0) begin
            h = q[0];
            chk({tag, ".pc"},    64'(bus.pop_pc_o),         64'(h.pc));
            chk({tag, ".itype"}, 64'(bus.pop_itype_o),      64'(h.itype));
            chk({tag, ".comp"},  64'(bus.pop_compressed_o), 64'(h.comp));
            chk({tag, ".priv"},  64'(bus.pop_priv_o),       64'(h.priv));
        end else begin
            chk({tag, ".pc_idle"}, 64'(bus.pop_pc_o), 64'(0));
        end
    endtask

    task automatic set_lane(input int k, input logic [XLEN-1:0] pc, input logic [ITYPE_LEN-1:0] it,
                            input logic c, input logic [PRIV_LEN-1:0] pv);
        bus.pc_i[k*XLEN +: XLEN]                = pc;
        bus.itype_i[k*ITYPE_LEN +: ITYPE_LEN]   = it;
        bus.compressed_i[k]                     = c;
        bus.priv_i[k*PRIV_LEN +: PRIV_LEN]      = pv;
    endtask

    // Reference behaviour for one clock edge, from the driven inputs
    task automatic model_update();
        int   n;
        int   free;
        uop_t u;
        if (bus.flush_i) begin
            q.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            n    = $countones(bus.valid_i);
            free = DEPTH - q.size();
            if (bus.pop_ready_i && q.size() != 0) void'(q.pop_front());
            if (n > 0 && n <= free) begin
                for (int k = 0; k < NRET; k++) begin
                    if (bus.valid_i[k]) begin
                        u.pc    = bus.pc_i[k*XLEN +: XLEN];
                        u.itype = bus.itype_i[k*ITYPE_LEN +: ITYPE_LEN];
                        u.comp  = bus.compressed_i[k];
                        u.priv  = bus.priv_i[k*PRIV_LEN +: PRIV_LEN];
                        q.push_back(u);
                    end
                end
            end else if (n > 0) begin
                m_ovf  = 1;
                m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
            end
        end
    endtask

    task automatic tick(input string tag, input logic fl, input logic [NRET-1:0] v, input logic rdy);
        bus.flush_i     = fl;
        bus.valid_i     = v;
        bus.pop_ready_i = rdy;
        if (bus.pop_valid_o && rdy && !fl) dut_popped.push_back(bus.pop_pc_o);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        total = 0; bad = 0; m_ovf = 0; m_drop = 0;
        rst = 1'b1;
        bus.flush_i = 1'b0; bus.valid_i = '0; bus.pop_ready_i = 1'b0;
        bus.pc_i = '0; bus.itype_i = '0; bus.compressed_i = '0; bus.priv_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all("reset");
        tick("idle", 1'b0, 2'b00, 1'b0);

        // Single upper-lane push: only lane 1 data may appear
        set_lane(0, 32'hDEAD_0000, 3'd1, 1'b1, 2'd1);
        set_lane(1, 32'h0000_0100, 3'd2, 1'b0, 2'd3);
        tick("lane1", 1'b0, 2'b10, 1'b0);
        chk("lane1.pc_const", 64'(bus.pop_pc_o), 64'h100);
        chk("lane1.cnt_const", 64'(bus.count_o), 64'd1);
        tick("lane1_pop", 1'b0, 2'b00, 1'b1);

        // Two-lane push in program order, pop while empty has no effect
        set_lane(0, 32'h0000_0200, 3'd5, 1'b0, 2'd3);
        set_lane(1, 32'h0000_0204, 3'd0, 1'b1, 2'd0);
        tick("pair", 1'b0, 2'b11, 1'b1);
        chk("pair.cnt2", 64'(bus.count_o), 64'd2);
        chk("pair.pc0", 64'(bus.pop_pc_o), 64'h200);
        chk("pair.it0", 64'(bus.pop_itype_o), 64'd5);
        tick("pair_pop0", 1'b0, 2'b00, 1'b1);
        chk("pair.cnt1", 64'(bus.count_o), 64'd1);
        chk("pair.pc1", 64'(bus.pop_pc_o), 64'h204);
        chk("pair.it1", 64'(bus.pop_itype_o), 64'd0);
        tick("pair_pop1", 1'b0, 2'b00, 1'b1);
        chk("pair.cnt0", 64'(bus.count_o), 64'd0);

        // Fill to 15, overflow a two-lane push, then a single lane still fits
        for (int i = 0; i < 7; i++) begin
            set_lane(0, 32'h3000 + 32'(8 * i), 3'd1, 1'b0, 2'd0);
            set_lane(1, 32'h3004 + 32'(8 * i), 3'd2, 1'b1, 2'd1);
            tick("fill", 1'b0, 2'b11, 1'b0);
        end
        set_lane(0, 32'h3100, 3'd3, 1'b0, 2'd2);
        tick("fill15", 1'b0, 2'b01, 1'b0);
        chk("fill15.cnt", 64'(bus.count_o), 64'd15);
        chk("fill15.pready", 64'(bus.push_ready_o), 64'd0);
        tick("ovf", 1'b0, 2'b11, 1'b0);
        chk("ovf.cnt", 64'(bus.count_o), 64'd15);
        chk("ovf.flag", 64'(bus.overflow_o), 64'd1);
        chk("ovf.drop", 64'(bus.drop_cnt_o), 64'd2);
        set_lane(1, 32'h3200, 3'd4, 1'b1, 2'd3);
        tick("last", 1'b0, 2'b10, 1'b0);
        chk("last.cnt", 64'(bus.count_o), 64'd16);
        chk("last.pready", 64'(bus.push_ready_o), 64'd0);

        // Flush beats a simultaneous push and pop
        tick("flush", 1'b1, 2'b11, 1'b1);
        chk("flush.cnt", 64'(bus.count_o), 64'd0);
        chk("flush.pvalid", 64'(bus.pop_valid_o), 64'd0);
        chk("flush.ovf", 64'(bus.overflow_o), 64'd0);
        chk("flush.drop", 64'(bus.drop_cnt_o), 64'd0);

        // Streaming push/pop across pointer wrap
        dut_popped.delete();
        for (int i = 0; i < 40; i++) begin
            set_lane(0, 32'h8000 + 32'(4 * i), 3'(i), 1'(i), 2'(i));
            tick("stream", 1'b0, 2'b01, 1'b1);
        end
        tick("stream_drain", 1'b0, 2'b00, 1'b1);
        chk("stream.npop", 64'(dut_popped.size()), 64'd40);
        for (int i = 0; i < 40 && i < dut_popped.size(); i++) begin
            chk("stream.seq", 64'(dut_popped[i]), 64'(32'h8000 + 32'(4 * i)));
        end

        // Random traffic, alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NRET; k++) begin
                set_lane(k, $urandom, 3'($urandom), 1'($urandom), 2'($urandom));
            end
            tick("rand", ($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
                 ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        // Make sure the FIFO is occupied, then reset between clock edges
        set_lane(0, 32'hA000, 3'd1, 1'b0, 2'd1);
        set_lane(1, 32'hA004, 3'd2, 1'b1, 2'd2);
        tick("pre_rst", 1'b0, 2'b11, 1'b0);
        tick("pre_rst2", 1'b0, 2'b11, 1'b0);
        bus.valid_i = '0;
        #2 rst = 1'b1;
        #1;
        chk("arst.cnt", 64'(bus.count_o), 64'd0);
        chk("arst.pvalid", 64'(bus.pop_valid_o), 64'd0);
        chk("arst.pready", 64'(bus.push_ready_o), 64'd1);
        chk("arst.pc", 64'(bus.pop_pc_o), 64'd0);
        q.delete(); m_ovf = 0; m_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        check_all("arst_rel");
        set_lane(0, 32'hB000, 3'd6, 1'b1, 2'd2);
        tick("post_rst", 1'b0, 2'b01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
